alu_execute_unit: RTL and testbench

- Registered execute-stage datapath for the 32-bit single-cycle MIPS core. It combines three functions:
  - ALU control decode (ALUop + function field → 3-bit ALU control).
  - A 32-bit ALU with a zero flag.
  - A general 32-bit carry adder, used for PC+4 and branch-target arithmetic.
- All results are captured in an output register stage, so latency is one clock.

---
 rtl/alu_execute_unit.sv | 81 ++++++++
 tb/tb_alu_execute_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_execute_unit.sv
// alu_execute_unit: registered MIPS execute stage (ALU control decode, 32-bit ALU with zero flag, carry adder)
// Ports: clock/reset (async active-high); in_valid, ALUop, function_code, alu_src1/alu_src2 (ALU operands),
//        add_a/add_b/add_cin (adder operands) in; out_valid, alu_ctr, alu_result, zero_bit, add_sum, add_cout
//        registered out, one cycle after the in_valid capture.
module alu_execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       ALUop,
  input  logic [5:0]       function_code,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  input  logic             add_cin,
  output logic             out_valid,
  output logic [2:0]       alu_ctr,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_bit,
  output logic [WIDTH-1:0] add_sum,
  output logic             add_cout
);
  localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010, C_XOR = 3'b011;
  localparam logic [2:0] C_NOR = 3'b100, C_SLTU = 3'b101, C_SUB = 3'b110, C_SLT = 3'b111;
  logic [2:0]       funct_ctr, ctr;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  always_comb begin
    funct_ctr = C_ADD;
    case (function_code)
      6'b100010: funct_ctr = C_SUB;
      6'b100100: funct_ctr = C_AND;
      6'b100101: funct_ctr = C_OR;
      6'b100110: funct_ctr = C_XOR;
      6'b100111: funct_ctr = C_NOR;
      6'b101010: funct_ctr = C_SLT;
      6'b101011: funct_ctr = C_SLTU;
      default:   funct_ctr = C_ADD;
    endcase
  end
  always_comb begin
    ctr = ALUop == 3'b000 ? funct_ctr :
          ALUop == 3'b010 ? C_SUB :
          ALUop == 3'b011 ? C_AND :
          ALUop == 3'b100 ? C_OR :
          ALUop == 3'b101 ? C_SLT :
          ALUop == 3'b110 ? C_XOR : C_ADD;
  end
  always_comb begin
    res = ctr == C_AND  ? alu_src1 & alu_src2 :
          ctr == C_OR   ? alu_src1 | alu_src2 :
          ctr == C_ADD  ? alu_src1 + alu_src2 :
          ctr == C_XOR  ? alu_src1 ^ alu_src2 :
          ctr == C_NOR  ? ~(alu_src1 | alu_src2) :
          ctr == C_SUB  ? alu_src1 - alu_src2 :
          ctr == C_SLTU ? {{(WIDTH-1){1'b0}}, alu_src1 < alu_src2} :
                          {{(WIDTH-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
  end
  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_ctr    <= 3'b000;
      alu_result <= '0;
      zero_bit   <= 1'b0;
      add_sum    <= '0;
      add_cout   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_ctr    <= ctr;
        alu_result <= res;
        zero_bit   <= res == '0;
        add_sum    <= sum[WIDTH-1:0];
        add_cout   <= sum[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit: directed table, corner sequences and randomized model check of alu_execute_unit
module tb_alu_execute_unit;
  logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, add_cin = 1'b0;
  logic [2:0]  ALUop = '0;
  logic [5:0]  function_code = '0;
  logic [31:0] alu_src1 = '0, alu_src2 = '0, add_a = '0, add_b = '0;
  logic        out_valid, zero_bit, add_cout;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_result, add_sum;
  int checks = 0, errors = 0;

  alu_execute_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .ALUop(ALUop), .function_code(function_code),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .out_valid(out_valid), .alu_ctr(alu_ctr), .alu_result(alu_result), .zero_bit(zero_bit),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  ctr;
    logic [31:0] res;
    logic        zero;
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  f;
    logic [31:0] a, b, aa, ab;
    logic        ci;
    exp_t        e;
  } vec_t;

  vec_t tbl[17];
  exp_t held;

  function automatic exp_t model(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a, b, aa, ab,
                                 input logic ci);
    exp_t r;
    longint s;
    string name;
    if (op == 3'd0)
      case (f)
        6'h22: name = "sub";  6'h24: name = "and";  6'h25: name = "or";   6'h26: name = "xor";
        6'h27: name = "nor";  6'h2a: name = "slt";  6'h2b: name = "sltu"; default: name = "add";
      endcase
    else
      case (op)
        3'd2: name = "sub"; 3'd3: name = "and"; 3'd4: name = "or";
        3'd5: name = "slt"; 3'd6: name = "xor"; default: name = "add";
      endcase
    case (name)
      "and":  begin r.ctr = 3'd0; r.res = a & b; end
      "or":   begin r.ctr = 3'd1; r.res = a | b; end
      "xor":  begin r.ctr = 3'd3; r.res = a ^ b; end
      "nor":  begin r.ctr = 3'd4; r.res = ~(a | b); end
      "sltu": begin r.ctr = 3'd5; r.res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0; end
      "sub":  begin r.ctr = 3'd6; r.res = 32'(longint'(a) - longint'(b)); end
      "slt":  begin r.ctr = 3'd7; r.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
      default: begin r.ctr = 3'd2; r.res = 32'(longint'(a) + longint'(b)); end
    endcase
    r.zero = r.res == 32'd0;
    s = longint'(aa) + longint'(ab) + longint'(ci);
    r.sum = s[31:0];
    r.cout = s[32];
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic [31:0] a, b, aa, ab, input logic ci);
    in_valid = v; ALUop = op; function_code = f;
    alu_src1 = a; alu_src2 = b; add_a = aa; add_b = ab; add_cin = ci;
  endtask

  task automatic check(input string n, input logic [63:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input exp_t e);
    check({tag, " out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, " alu_ctr"}, 64'(alu_ctr), 64'(e.ctr));
    check({tag, " alu_result"}, 64'(alu_result), 64'(e.res));
    check({tag, " zero_bit"}, 64'(zero_bit), 64'(e.zero));
    check({tag, " add_sum"}, 64'(add_sum), 64'(e.sum));
    check({tag, " add_cout"}, 64'(add_cout), 64'(e.cout));
  endtask

  initial begin
    exp_t z;
    logic [5:0] fl[8];
    z = '{3'd0, 32'd0, 1'b0, 32'd0, 1'b0};
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    tbl[0]  = '{3'd0, 6'h20, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, '{3'd2, 32'd0, 1'b1, 32'd0, 1'b0}};
    tbl[1]  = '{3'd2, 6'h00, 32'h12345678, 32'h12345678, 32'd0, 32'd0, 1'b0, '{3'd6, 32'd0, 1'b1, 32'd0, 1'b0}};
    tbl[2]  = '{3'd2, 6'h00, 32'h12345678, 32'h12345679, 32'd0, 32'd0, 1'b0, '{3'd6, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0}};
    tbl[3]  = '{3'd0, 6'h2a, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, '{3'd7, 32'd1, 1'b0, 32'd0, 1'b0}};
    tbl[4]  = '{3'd0, 6'h2b, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, '{3'd5, 32'd0, 1'b1, 32'd0, 1'b0}};
    tbl[5]  = '{3'd5, 6'h00, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, '{3'd7, 32'd1, 1'b0, 32'd0, 1'b0}};
    tbl[6]  = '{3'd1, 6'h00, 32'd1, 32'd2, 32'h00400000, 32'd4, 1'b0, '{3'd2, 32'd3, 1'b0, 32'h00400004, 1'b0}};
    tbl[7]  = '{3'd4, 6'h00, 32'hF0, 32'h0F, 32'hFFFFFFFC, 32'd4, 1'b1, '{3'd1, 32'hFF, 1'b0, 32'd1, 1'b1}};
    tbl[8]  = '{3'd3, 6'h00, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 1'b0, '{3'd0, 32'h00F0, 1'b0, 32'd0, 1'b0}};
    tbl[9]  = '{3'd0, 6'h00, 32'h10, 32'h20, 32'd0, 32'd0, 1'b0, '{3'd2, 32'h30, 1'b0, 32'd0, 1'b0}};
    tbl[10] = '{3'd7, 6'h22, 32'd7, 32'd8, 32'd0, 32'd0, 1'b0, '{3'd2, 32'hF, 1'b0, 32'd0, 1'b0}};
    tbl[11] = '{3'd0, 6'h27, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, '{3'd4, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0}};
    tbl[12] = '{3'd6, 6'h00, 32'hFF00, 32'h0F0F, 32'd0, 32'd0, 1'b0, '{3'd3, 32'hF00F, 1'b0, 32'd0, 1'b0}};
    tbl[13] = '{3'd0, 6'h24, 32'hFFFF0000, 32'h12345678, 32'd0, 32'd0, 1'b0, '{3'd0, 32'h12340000, 1'b0, 32'd0, 1'b0}};
    tbl[14] = '{3'd0, 6'h22, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, '{3'd6, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b1}};
    tbl[15] = '{3'd0, 6'h25, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd1, 1'b0, '{3'd1, 32'd0, 1'b1, 32'h80000000, 1'b0}};
    tbl[16] = '{3'd0, 6'h26, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, '{3'd3, 32'd0, 1'b1, 32'd0, 1'b0}};

    drive(1'b1, 3'd4, 6'h00, 32'h55, 32'hAA, 32'd9, 32'd9, 1'b1);
    step();
    step();
    check_all("reset_hold", 1'b0, z);
    reset = 1'b0;
    step();
    check_all("pre_reset_op", 1'b1, '{3'd1, 32'hFF, 1'b0, 32'd19, 1'b0});
    #2 reset = 1'b1;
    #1 check_all("async_reset", 1'b0, z);
    #1 reset = 1'b0;
    drive(1'b0, 3'd4, 6'h00, 32'h55, 32'hAA, 32'd9, 32'd9, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_all($sformatf("idle_after_reset%0d", i), 1'b0, z);
    end

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].aa, tbl[i].ab, tbl[i].ci);
      step();
      check_all($sformatf("vec%0d", i), 1'b1, tbl[i].e);
    end

    drive(1'b0, 3'd1, 6'h20, 32'h11111111, 32'h22222222, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_all($sformatf("hold%0d", i), 1'b0, tbl[16].e);
    end

    held = tbl[16].e;
    for (int i = 0; i < 400; i++) begin
      logic        v, ci;
      logic [2:0]  op;
      logic [5:0]  f;
      logic [31:0] a, b, aa, ab;
      v = $urandom_range(0, 3) != 0;
      op = 3'($urandom_range(0, 7));
      f = $urandom_range(0, 1) ? fl[$urandom_range(0, 7)] : 6'($urandom);
      a = $urandom;
      b = $urandom_range(0, 4) == 0 ? a : $urandom;
      if ($urandom_range(0, 5) == 0) a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom_range(0, 3))};
      aa = $urandom;
      ab = $urandom_range(0, 3) == 0 ? ~aa : $urandom;
      ci = 1'($urandom);
      drive(v, op, f, a, b, aa, ab, ci);
      if (v) held = model(op, f, a, b, aa, ab, ci);
      step();
      check_all($sformatf("rand%0d", i), v, held);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
